led_bank_arbiter: RTL and testbench

LED_BANK_ARBITER -- requirements
Module: led_bank_arbiter

---
 rtl/led_bank_arbiter.sv | 136 +++++++++++++
 tb/tb_led_bank_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/led_bank_arbiter.sv
// LED bank arbiter: three requesters share one bank of five LEDs plus an
// active-low green/red pair. Round-robin grants with a minimum hold before
// preemption, a one-cycle blank gap between owners, and a free-running
// counter pattern on the LEDs while nobody owns the bank.
module led_bank_arbiter #(
    parameter int unsigned MIN_HOLD = 1200000,
    parameter int unsigned IDLE_N   = 24
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [2:0] REQ,
    input  logic [6:0] PAT0,
    input  logic [6:0] PAT1,
    input  logic [6:0] PAT2,
    output logic [2:0] GNT,
    output logic       BUSY,
    output logic       LED1,
    output logic       LED2,
    output logic       LED3,
    output logic       LED4,
    output logic       LED5,
    output logic       LEDG_N,
    output logic       LEDR_N
);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    // hold_cnt reads 0 on the first granted cycle, so the owner has served
    // MIN_HOLD cycles once it reaches MIN_HOLD-1 at an edge.
    localparam logic [23:0] HOLD_LAST = 24'(MIN_HOLD - 1);
    localparam logic [23:0] HOLD_MAX  = 24'(MIN_HOLD);

    state_t         state;
    logic [IDLE_N:0] cnt;
    logic [23:0]    hold_cnt;
    logic [1:0]     last_owner;
    logic [1:0]     owner;
    logic [6:0]     leds;      // physical levels {LED5..LED1, LEDG_N, LEDR_N}

    logic [1:0]     sel;
    logic [6:0]     sel_pat;
    logic [6:0]     own_pat;
    logic [2:0]     own_mask;
    logic           own_req;
    logic           others;
    logic           hold_done;

    // Logical pattern -> pin levels: green/red are active-low.
    function automatic logic [6:0] phys(input logic [6:0] v);
        return {v[6:2], ~v[1:0]};
    endfunction

    // Rotating priority: search starts one past the previous owner.
    always_comb begin
        sel = 2'd0;
        case (last_owner)
            2'd0:    sel = REQ[1] ? 2'd1 : (REQ[2] ? 2'd2 : 2'd0);
            2'd1:    sel = REQ[2] ? 2'd2 : (REQ[0] ? 2'd0 : 2'd1);
            default: sel = REQ[0] ? 2'd0 : (REQ[1] ? 2'd1 : 2'd2);
        endcase
    end

    // Pattern muxes for the requester being granted and the current owner.
    always_comb begin
        sel_pat = PAT2;
        own_pat = PAT2;
        case (sel)
            2'd0:    sel_pat = PAT0;
            2'd1:    sel_pat = PAT1;
            default: sel_pat = PAT2;
        endcase
        case (owner)
            2'd0:    own_pat = PAT0;
            2'd1:    own_pat = PAT1;
            default: own_pat = PAT2;
        endcase
    end

    // Preemption terms: owner's own request and anyone else waiting.
    always_comb begin
        own_mask  = 3'b001 << owner;
        own_req   = |(REQ & own_mask);
        others    = |(REQ & ~own_mask);
        hold_done = (hold_cnt >= HOLD_LAST);
    end

    // Arbiter FSM with registered grant, busy and LED outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            GNT        <= 3'b000;
            BUSY       <= 1'b0;
            cnt        <= '0;
            hold_cnt   <= '0;
            last_owner <= 2'd2;
            owner      <= 2'd0;
            leds       <= phys(7'h00);
        end else begin
            cnt <= cnt + {{IDLE_N{1'b0}}, 1'b1};
            case (state)
                IDLE, GAP: begin
                    if (|REQ) begin
                        state      <= GRANT;
                        GNT        <= 3'b001 << sel;
                        BUSY       <= 1'b1;
                        last_owner <= sel;
                        owner      <= sel;
                        hold_cnt   <= '0;
                        leds       <= phys(sel_pat);
                    end else begin
                        state <= IDLE;
                        GNT   <= 3'b000;
                        BUSY  <= 1'b0;
                        leds  <= phys(cnt[IDLE_N -: 7]);
                    end
                end
                GRANT: begin
                    if (!own_req || (hold_done && others)) begin
                        state <= GAP;
                        GNT   <= 3'b000;
                        BUSY  <= 1'b0;
                        leds  <= phys(7'h00);
                    end else begin
                        leds <= phys(own_pat);
                        if (hold_cnt != HOLD_MAX)
                            hold_cnt <= hold_cnt + 24'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign {LED5, LED4, LED3, LED2, LED1, LEDG_N, LEDR_N} = leds;

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Bench for led_bank_arbiter: directed scenarios followed by random traffic,
// all compared each cycle against a cycle-count/ownership reference model.
module tb_led_bank_arbiter;

    localparam int MH = 4;
    localparam int IN = 8;
    localparam int CNT_MOD = 1 << (IN + 1);

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [2:0] REQ = 3'b000;
    logic [6:0] PAT0 = 7'h00, PAT1 = 7'h00, PAT2 = 7'h00;
    logic [2:0] GNT;
    logic       BUSY, LED1, LED2, LED3, LED4, LED5, LEDG_N, LEDR_N;

    int n_checks = 0;
    int n_fail   = 0;

    led_bank_arbiter #(.MIN_HOLD(MH), .IDLE_N(IN)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ),
        .PAT0(PAT0), .PAT1(PAT1), .PAT2(PAT2),
        .GNT(GNT), .BUSY(BUSY),
        .LED1(LED1), .LED2(LED2), .LED3(LED3), .LED4(LED4), .LED5(LED5),
        .LEDG_N(LEDG_N), .LEDR_N(LEDR_N)
    );

    always #5 CLK = ~CLK;

    // Reference model: mode 0 = idle, 1 = owned, 2 = blank gap.
    int         m_mode  = 0;
    int         m_owner = 0;
    int         m_last  = 2;
    int         m_held  = 0;   // cycles the current owner has been shown
    int         m_cnt   = 0;   // edges since reset, modulo counter size
    logic [6:0] m_led   = 7'h00;
    logic [2:0] m_gnt   = 3'b000;

    function automatic logic [6:0] pins(input logic [6:0] v);
        return {v[6:2], ~v[1], ~v[0]};
    endfunction

    function automatic logic [6:0] pat_of(input int i);
        return (i == 0) ? PAT0 : (i == 1) ? PAT1 : PAT2;
    endfunction

    task automatic model_grant();
        for (int k = 1; k <= 3; k++) begin
            int c;
            c = (m_last + k) % 3;
            if (REQ[c]) begin
                m_owner = c;
                m_last  = c;
                m_gnt   = 3'(1 << c);
                m_led   = pat_of(c);
                m_held  = 1;
                m_mode  = 1;
                break;
            end
        end
    endtask

    task automatic model_step();
        int old_cnt;
        if (RST) begin
            m_mode = 0; m_gnt = 3'b000; m_led = 7'h00;
            m_cnt = 0; m_held = 0; m_last = 2;
            return;
        end
        old_cnt = m_cnt;
        m_cnt   = (m_cnt + 1) % CNT_MOD;
        if (m_mode == 1) begin
            if (!REQ[m_owner] || (m_held >= MH && (REQ & ~(3'(1 << m_owner))) != 0)) begin
                m_mode = 2; m_gnt = 3'b000; m_led = 7'h00;
            end else begin
                m_led  = pat_of(m_owner);
                m_held = m_held + 1;
            end
        end else if (REQ != 3'b000) begin
            model_grant();
        end else begin
            m_mode = 0;
            m_gnt  = 3'b000;
            m_led  = 7'((old_cnt >> (IN - 6)) % 128);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] dut_leds();
        return {LED5, LED4, LED3, LED2, LED1, LEDG_N, LEDR_N};
    endfunction

    // One clock: edge, advance model, then compare away from the edge.
    task automatic cyc();
        @(posedge CLK);
        model_step();
        #1;
        chk("gnt",    32'(GNT), 32'(m_gnt));
        chk("busy",   32'(BUSY), 32'(m_gnt != 3'b000));
        chk("leds",   32'(dut_leds()), 32'(pins(m_led)));
        chk("onehot", 32'($countones(GNT) <= 1), 32'd1);
    endtask

    logic [2:0] g_hist [0:19];
    logic [6:0] p2;
    bit         seen;

    initial begin
        // Reset state
        RST = 1'b1; REQ = 3'b000;
        cyc(); cyc();
        chk("rst_gnt",  32'(GNT), 32'd0);
        chk("rst_leds", 32'(dut_leds()), 32'h03);

        // Idle counter pattern across the 127 -> 0 wrap of cnt[8:2]
        RST = 1'b0;
        for (int i = 0; i < 600; i++) cyc();

        // All three requesting: 4-cycle grants rotating 0,1,2,0 with gaps
        REQ = 3'b111;
        PAT0 = 7'h11; PAT1 = 7'h22; PAT2 = 7'h44;
        for (int i = 0; i < 20; i++) begin
            cyc();
            g_hist[i] = GNT;
        end
        for (int i = 0; i < 20; i++)
            chk("rr_order", 32'(g_hist[i]), (i % 5 == 4) ? 32'd0 : 32'(1 << ((i / 5) % 3)));

        // Lone requester 1 holds indefinitely with pattern 0x55
        RST = 1'b1; REQ = 3'b000; cyc();
        RST = 1'b0; REQ = 3'b010; PAT1 = 7'h55;
        for (int i = 0; i < 40; i++) begin
            PAT0 = 7'($urandom); PAT2 = 7'($urandom);
            cyc();
        end
        chk("hold_gnt",  32'(GNT), 32'h2);
        chk("hold_leds", 32'(dut_leds()), 32'h56);

        // Owner 0 drops after one held cycle: gap then idle
        REQ = 3'b000; cyc(); cyc(); cyc();
        REQ = 3'b001; cyc(); cyc();
        REQ = 3'b000; cyc();
        chk("drop_gap_gnt",  32'(GNT), 32'd0);
        chk("drop_gap_leds", 32'(dut_leds()), 32'h03);
        cyc();
        chk("drop_idle_busy", 32'(BUSY), 32'd0);

        // Reset mid-grant of requester 2, then 0 wins over 2
        RST = 1'b1; cyc();
        RST = 1'b0; REQ = 3'b100; cyc(); cyc();
        chk("pre_rst_gnt", 32'(GNT), 32'h4);
        RST = 1'b1; cyc();
        chk("mid_rst_gnt",  32'(GNT), 32'd0);
        chk("mid_rst_busy", 32'(BUSY), 32'd0);
        chk("mid_rst_leds", 32'(dut_leds()), 32'h03);
        RST = 1'b0; REQ = 3'b101; cyc();
        chk("post_rst_first", 32'(GNT), 32'h1);

        // Requester 2 owns while PAT2 changes every cycle
        REQ = 3'b100;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            cyc();
            seen = (GNT == 3'b100);
        end
        chk("track_got_grant", 32'(seen), 32'd1);
        for (int i = 0; i < 20; i++) begin
            p2 = 7'($urandom);
            PAT2 = p2;
            cyc();
            chk("track_pat2", 32'(dut_leds()), 32'(pins(p2)));
        end

        // Random traffic
        RST = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 3; b++)
                if ($urandom_range(7) == 0) REQ[b] = ~REQ[b];
            PAT0 = 7'($urandom); PAT1 = 7'($urandom); PAT2 = 7'($urandom);
            RST  = ($urandom_range(199) == 0);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
